// File: rtl/mcp_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mcp_bus_pkg                                                |
// | Brief   : MCP bus register map, opcodes, FSM states, byte select.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mcp_bus_pkg;

    localparam logic [2:0] ADDR_AH = 3'd0;
    localparam logic [2:0] ADDR_AL = 3'd1;
    localparam logic [2:0] ADDR_BH = 3'd2;
    localparam logic [2:0] ADDR_BL = 3'd3;
    localparam logic [2:0] ADDR_OP = 3'd4;

    localparam logic [2:0] ADDR_X0 = 3'd0;
    localparam logic [2:0] ADDR_X1 = 3'd1;
    localparam logic [2:0] ADDR_X2 = 3'd2;
    localparam logic [2:0] ADDR_X3 = 3'd3;

    localparam logic [7:0] OP_sInt16_MULT     = 8'd0;
    localparam logic [7:0] OP_sInt16_DIVMOD   = 8'd1;
    localparam logic [7:0] OP_sInt16_DIVFRACT = 8'd2;
    localparam logic [7:0] OP_sInt16_SQRT     = 8'd3;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        W_SETUP  = 4'd1,
        W_STROBE = 4'd2,
        W_HOLD   = 4'd3,
        CALC     = 4'd4,
        R_SETUP  = 4'd5,
        R_STROBE = 4'd6,
        R_HOLD   = 4'd7,
        DONE     = 4'd8
    } mcpState_t;

    function automatic logic [7:0] writeByte(input logic [15:0] a, input logic [15:0] b,
                                             input logic [7:0] op, input logic [2:0] idx);
        case (idx)
            ADDR_AH: return a[15:8];
            ADDR_AL: return a[7:0];
            ADDR_BH: return b[15:8];
            ADDR_BL: return b[7:0];
            default: return op;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcp_bus_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mcp_bus_timer                                              |
// | Brief   : Loadable down-counter; o_zero marks the last cycle.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mcp_bus_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mcp_bus_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mcp_bus_initiator                                          |
// | Brief   : MCP bus host: 5 byte writes, compute wait, 4 byte reads.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mcp_bus_initiator
    import mcp_bus_pkg::*;
#(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 2,
    parameter int CALC_CYC   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    input  logic [7:0]  op_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] x_out,
    output logic [2:0]  addressBus,
    output logic        writeBus,
    output logic        readBus,
    output logic [7:0]  data_out,
    output logic        data_oe,
    input  logic [7:0]  data_in
);

    localparam int c_maxCyc = (CALC_CYC > SETUP_CYC && CALC_CYC > STROBE_CYC && CALC_CYC > HOLD_CYC) ? CALC_CYC :
                              (SETUP_CYC > STROBE_CYC && SETUP_CYC > HOLD_CYC) ? SETUP_CYC :
                              (STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC;
    localparam int c_timerWidth = $clog2(c_maxCyc + 1);

    mcpState_t               r_state, w_next;
    logic [2:0]              r_idx, w_idxNext;
    logic [15:0]             r_a, r_b, w_aSrc, w_bSrc;
    logic [7:0]              r_op, w_opSrc;
    logic [2:0]              r_addr;
    logic [7:0]              r_dataOut;
    logic [31:0]             r_shadow, r_x;
    logic                    w_load, w_zero;
    logic [c_timerWidth-1:0] w_loadValue;

    mcp_bus_timer #(.WIDTH(c_timerWidth)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_loadValue (w_loadValue),
        .o_zero      (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_idxNext = r_idx;
        case (r_state)
            IDLE:     if (start) begin w_next = W_SETUP; w_idxNext = 3'd0; end
            W_SETUP:  if (w_zero) w_next = W_STROBE;
            W_STROBE: if (w_zero) w_next = W_HOLD;
            W_HOLD:   if (w_zero) begin
                          if (r_idx < ADDR_OP) begin w_next = W_SETUP; w_idxNext = r_idx + 3'd1; end
                          else w_next = CALC;
                      end
            CALC:     if (w_zero) begin w_next = R_SETUP; w_idxNext = 3'd0; end
            R_SETUP:  if (w_zero) w_next = R_STROBE;
            R_STROBE: if (w_zero) w_next = R_HOLD;
            R_HOLD:   if (w_zero) begin
                          if (r_idx < ADDR_X3) begin w_next = R_SETUP; w_idxNext = r_idx + 3'd1; end
                          else w_next = DONE;
                      end
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase

        // Timer reloads with (length-1) so that w_zero flags the final cycle of each state.
        w_load = (w_next != r_state);
        case (w_next)
            W_SETUP, R_SETUP:   w_loadValue = c_timerWidth'(SETUP_CYC - 1);
            W_STROBE, R_STROBE: w_loadValue = c_timerWidth'(STROBE_CYC - 1);
            W_HOLD, R_HOLD:     w_loadValue = c_timerWidth'(HOLD_CYC - 1);
            CALC:               w_loadValue = c_timerWidth'(CALC_CYC - 1);
            default:            w_loadValue = '0;
        endcase

        writeBus   = (r_state != W_STROBE);
        readBus    = (r_state != R_STROBE);
        data_oe    = (r_state == W_SETUP) || (r_state == W_STROBE) || (r_state == W_HOLD);
        busy       = (r_state != IDLE) && (r_state != DONE);
        done       = (r_state == DONE);
        addressBus = r_addr;
        data_out   = r_dataOut;
        x_out      = r_x;
    end

    // The first write byte is loaded on the accept edge, before operands are latched.
    assign w_aSrc  = (r_state == IDLE) ? a_in  : r_a;
    assign w_bSrc  = (r_state == IDLE) ? b_in  : r_b;
    assign w_opSrc = (r_state == IDLE) ? op_in : r_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_addr    <= '0;
            r_dataOut <= '0;
            r_shadow  <= '0;
            r_x       <= '0;
        end else begin
            r_idx <= w_idxNext;
            if (r_state == IDLE && start) begin
                r_a  <= a_in;
                r_b  <= b_in;
                r_op <= op_in;
            end
            if (w_load && (w_next == W_SETUP || w_next == R_SETUP)) begin
                r_addr <= w_idxNext;
            end
            if (w_load && w_next == W_SETUP) begin
                r_dataOut <= writeByte(w_aSrc, w_bSrc, w_opSrc, w_idxNext);
            end
            if (r_state == R_STROBE && w_zero) begin
                case (r_idx)
                    ADDR_X0: r_shadow[31:24] <= data_in;
                    ADDR_X1: r_shadow[23:16] <= data_in;
                    ADDR_X2: r_shadow[15:8]  <= data_in;
                    default: r_shadow[7:0]   <= data_in;
                endcase
            end
            if (w_next == DONE && r_state != DONE) begin
                r_x <= r_shadow;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mcp_bus_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mcp_bus_initiator                                       |
// | Brief   : Coprocessor model, bus monitor and scoreboard for the host.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mcp_bus_initiator;

    localparam int STROBE = 3;
    localparam int LATENCY = 127;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] a_in, b_in;
    logic [7:0]  op_in, data_out, data_in;
    logic        busy, done, writeBus, readBus, data_oe;
    logic [31:0] x_out;
    logic [2:0]  addressBus;

    int nAsserts = 0;
    int nFails = 0;

    mcp_bus_initiator dut (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .busy(busy), .done(done), .x_out(x_out), .addressBus(addressBus), .writeBus(writeBus),
        .readBus(readBus), .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic of the coprocessor, signed int16 operands.
    function automatic logic [31:0] mcpCompute(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op);
        longint sa, sb, q, r, v, root, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            8'd0: begin q = sa * sb; return q[31:0]; end
            8'd1: begin
                if (sb == 0) return 32'hFFFF_FFFF;
                q = sa / sb; r = sa % sb;
                return {q[15:0], r[15:0]};
            end
            8'd2: begin
                if (sb == 0) return 32'hFFFF_FFFF;
                q = (sa * 65536) / sb;
                return q[31:0];
            end
            8'd3: begin
                v = longint'(a) << 32;
                root = 0;
                for (int i = 24; i >= 0; i--) begin
                    t = root | (longint'(1) << i);
                    if (t * t <= v) root = t;
                end
                return root[31:0];
            end
            default: return 32'h0;
        endcase
    endfunction

    // Coprocessor model: register file written on strobe fall, result served on reads.
    logic [7:0]  copRegs [0:7];
    logic [31:0] copX = 32'h0;

    always_comb begin
        data_in = 8'hA5;
        if (!readBus) begin
            case (addressBus)
                3'd0: data_in = copX[31:24];
                3'd1: data_in = copX[23:16];
                3'd2: data_in = copX[15:8];
                3'd3: data_in = copX[7:0];
                default: data_in = 8'hA5;
            endcase
        end
    end

    typedef struct packed {
        logic       isWrite;
        logic [2:0] addr;
        logic [7:0] data;
    } busEvt_t;

    busEvt_t evtQ[$];
    int      wLow = 0, rLow = 0;
    logic    prevW = 1'b1, prevR = 1'b1;

    always @(negedge clk) begin
        if (reset) begin
            evtQ.delete();
            wLow = 0; rLow = 0; prevW = 1'b1; prevR = 1'b1;
        end else begin
            if (!writeBus || !readBus) chk("noOverlap", {31'b0, ~writeBus & ~readBus}, 32'd0);
            if (!readBus) chk("oeInRead", {31'b0, data_oe}, 32'd0);
            if (!writeBus && prevW) begin
                chk("oeInWrite", {31'b0, data_oe}, 32'd1);
                evtQ.push_back('{1'b1, addressBus, data_out});
                copRegs[addressBus] = data_out;
                if (addressBus == 3'd4)
                    copX = mcpCompute({copRegs[0], copRegs[1]}, {copRegs[2], copRegs[3]}, copRegs[4]);
            end
            if (!readBus && prevR) evtQ.push_back('{1'b0, addressBus, data_in});
            if (!writeBus) wLow++;
            else if (!prevW) begin chk("wStrobeLen", wLow, STROBE); wLow = 0; end
            if (!readBus) rLow++;
            else if (!prevR) begin chk("rStrobeLen", rLow, STROBE); rLow = 0; end
            prevW = writeBus;
            prevR = readBus;
        end
    end

    task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic [7:0] op,
                         input logic [31:0] expX, input bit pokeStart);
        int cycles;
        busEvt_t exp;
        logic [7:0] wBytes [0:4];
        wBytes[0] = a[15:8]; wBytes[1] = a[7:0]; wBytes[2] = b[15:8]; wBytes[3] = b[7:0]; wBytes[4] = op;
        @(negedge clk);
        evtQ.delete();
        a_in = a; b_in = b; op_in = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = 16'($urandom); b_in = 16'($urandom); op_in = 8'($urandom);
        chk("busyAfterAccept", {31'b0, busy}, 32'd1);
        cycles = 0;
        while (!done && cycles < 400) begin
            if (pokeStart) start = (cycles == 40);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        chk("latency", cycles, LATENCY);
        chk("xAtDone", x_out, expX);
        chk("busyAtDone", {31'b0, busy}, 32'd0);
        if (pokeStart) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("donePulse", {31'b0, done}, 32'd0);
        chk("xHold", x_out, expX);
        if (pokeStart) begin
            chk("startInDoneIgnored", {31'b0, busy}, 32'd0);
            repeat (10) @(posedge clk);
            #1;
        end
        chk("evtCount", evtQ.size(), 9);
        for (int i = 0; i < 9 && i < evtQ.size(); i++) begin
            if (i < 5) exp = '{1'b1, 3'(i), wBytes[i]};
            else       exp = '{1'b0, 3'(i - 5), expX[31 - 8*(i-5) -: 8]};
            chk($sformatf("evt%0d", i), {20'b0, evtQ[i]}, {20'b0, exp});
        end
    endtask

    initial begin
        int cycles;
        logic [15:0] ra, rb;
        logic [7:0]  rop;
        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; op_in = '0;
        for (int i = 0; i < 8; i++) copRegs[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rstWrite", {31'b0, writeBus}, 32'd1);
        chk("rstRead", {31'b0, readBus}, 32'd1);
        chk("rstAddr", {29'b0, addressBus}, 32'd0);
        chk("rstOe", {31'b0, data_oe}, 32'd0);
        chk("rstData", {24'b0, data_out}, 32'd0);
        chk("rstBusy", {31'b0, busy}, 32'd0);
        chk("rstDone", {31'b0, done}, 32'd0);
        chk("rstX", x_out, 32'd0);
        reset = 1'b0;

        runOp(16'h7FFF, 16'h7FFF, 8'd0, 32'h3FFF_0001, 1'b0);
        runOp(16'hFFF0, 16'h0003, 8'd1, 32'hFFFB_FFFF, 1'b0);
        runOp(16'h0003, 16'h0002, 8'd2, 32'h0001_8000, 1'b1);

        // Abort in the middle of a read strobe.
        @(negedge clk);
        a_in = 16'h0003; b_in = 16'h0002; op_in = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        while (readBus && cycles < 400) begin @(negedge clk); cycles++; end
        chk("reachReadStrobe", {31'b0, readBus}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abortRead", {31'b0, readBus}, 32'd1);
        chk("abortWrite", {31'b0, writeBus}, 32'd1);
        chk("abortBusy", {31'b0, busy}, 32'd0);
        chk("abortX", x_out, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("noBusAfterAbort", evtQ.size(), 0);
        runOp(16'h0004, 16'h0000, 8'd3, 32'h0002_0000, 1'b0);

        for (int n = 0; n < 10; n++) begin
            rop = 8'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rop != 8'd0 && rb == 16'h0) rb = 16'h0001;
            if (rop == 8'd3) ra[15] = 1'b0;
            runOp(ra, rb, rop, mcpCompute(ra, rb, rop), 1'(n % 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
`default_nettype wire
